// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction-memory boot loader
package mips_pkg;

    localparam int BYTES_PER_WORD     = 4;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } boot_state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs a big-endian byte stream into 32-bit words
module word_assembler
    import mips_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_shift_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_shift_en) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    // The word is presented together with its final byte so the caller can latch it on that edge.
    assign o_word      = {r_shift, i_byte};
    assign o_word_full = i_shift_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream loader into instruction memory; optional BOOT_CHECKSUM_EN
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MAX_WORDS  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [31:0]           imem_wr_data,
    output logic                  cpu_reset_n,
    output logic                  boot_done,
    output logic                  boot_error
);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t ST_FINAL = ST_CHK;
`else
    localparam boot_state_t ST_FINAL = ST_DONE;
`endif

    boot_state_t           r_state;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_len;
    logic [16:0]           r_words;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [31:0]           r_wr_data;

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_len_too_big;
    logic        w_last_word;
    logic [31:0] w_word;
    logic        w_word_full;

    assign rx_ready      = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                           (r_state == ST_DATA)   || (r_state == ST_CHK);
    assign w_accept      = rx_valid && rx_ready;
    assign w_len         = {r_len_hi, rx_data};
    assign w_len_too_big = 32'(w_len) > $unsigned(32'(MAX_WORDS));
    assign w_last_word   = (r_words + 17'd1) >= {1'b0, r_len};

    word_assembler u_word_assembler (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_shift_en  (w_accept && (r_state == ST_DATA)),
        .i_byte      (rx_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum <= '0;
        end else if (w_accept && (r_state != ST_CHK)) begin
            r_csum <= r_csum ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_LEN_HI;
            r_len_hi  <= '0;
            r_len     <= '0;
            r_words   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                ST_LEN_HI: if (w_accept) begin
                    r_len_hi <= rx_data;
                    r_state  <= ST_LEN_LO;
                end
                ST_LEN_LO: if (w_accept) begin
                    r_len <= w_len;
                    if (w_len_too_big)      r_state <= ST_ERROR;
                    else if (w_len == 16'd0) r_state <= ST_FINAL;
                    else                    r_state <= ST_DATA;
                end
                ST_DATA: if (w_word_full) begin
                    r_wr_data <= w_word;
                    r_wr_addr <= r_words[ADDR_WIDTH-1:0];
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_words <= r_words + 17'd1;
                    r_state <= w_last_word ? ST_FINAL : ST_DATA;
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CHK: if (w_accept) begin
                    r_state <= (rx_data == r_csum) ? ST_DONE : ST_ERROR;
                end
`endif
                default: r_state <= r_state;
            endcase
        end
    end

    assign imem_wr_en   = (r_state == ST_WRITE);
    assign imem_wr_addr = r_wr_addr;
    assign imem_wr_data = r_wr_data;
    assign cpu_reset_n  = (r_state == ST_DONE);
    assign boot_done    = (r_state == ST_DONE);
    assign boot_error   = (r_state == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized self-checking bench against a stream-level reference model
module tb_imem_boot_loader;

    localparam int AW = 8;
    localparam int MW = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic          cpu_reset_n;
    logic          boot_done;
    logic          boot_error;

    imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_reset_n  (cpu_reset_n),
        .boot_done    (boot_done),
        .boot_error   (boot_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    logic [7:0]  stream[$];
    int          acc_cyc[$];
    int          got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_byte[$];
    bit          exp_done;
    bit          exp_err;

    always @(negedge clk) begin
        if (reset && imem_wr_en) begin
            got_addr.push_back(int'(imem_wr_addr));
            got_data.push_back(imem_wr_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic start_stream(input int len);
        stream.delete();
        stream.push_back(8'(len >> 8));
        stream.push_back(8'(len));
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) stream.push_back(8'(w >> (8 * b)));
    endtask

    task automatic finish_stream();
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        stream.push_back(x);
`endif
    endtask

    // Reference: derive the expected write list and final outcome straight from the byte stream.
    task automatic model_stream();
        int len;
        len = (int'(stream[0]) << 8) | int'(stream[1]);
        exp_addr.delete(); exp_data.delete(); exp_byte.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (len > MW) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
                exp_byte.push_back(5 + 4*i);
            end
`ifdef BOOT_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 0; i < 2 + 4*len; i++) x = x ^ stream[i];
                exp_done = (stream[2+4*len] == x);
                exp_err  = !exp_done;
            end
`else
            exp_done = 1'b1;
`endif
        end
    endtask

    task automatic drive(input string name, input bit rnd, input int limit);
        int idx;
        int waited;
        idx = 0;
        waited = 0;
        acc_cyc.delete();
        while (idx < limit && waited < 200) begin
            @(negedge clk);
            if (rnd && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = stream[idx];
            end
            if (rx_valid && rx_ready) begin
                acc_cyc.push_back(cyc + 1);
                idx++;
                waited = 0;
            end else begin
                waited++;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        chk_eq({name, "_bytes_accepted"}, 32'(idx), 32'(limit));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("rst_wr_en",   32'(imem_wr_en),   32'd0);
        chk_eq("rst_wr_addr", 32'(imem_wr_addr), 32'd0);
        chk_eq("rst_wr_data", imem_wr_data,      32'd0);
        chk_eq("rst_flags",   {29'd0, cpu_reset_n, boot_done, boot_error}, 32'd0);
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        reset = 1'b1;
        @(negedge clk);
        chk_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic run_and_check(input string name, input bit rnd);
        int n;
        model_stream();
        drive(name, rnd, exp_err && exp_addr.size() == 0 && !exp_done &&
                         stream.size() == 2 ? 2 : stream.size());
        repeat (3) @(negedge clk);
        chk_eq({name, "_n_writes"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk_eq({name, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
            chk_eq({name, "_data"}, got_data[i], exp_data[i]);
            if (exp_byte[i] < acc_cyc.size())
                chk_eq({name, "_latency"}, 32'(got_cyc[i]), 32'(acc_cyc[exp_byte[i]]));
        end
        chk_eq({name, "_done"},        32'(boot_done),   32'(exp_done));
        chk_eq({name, "_error"},       32'(boot_error),  32'(exp_err));
        chk_eq({name, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(exp_done));
        chk_eq({name, "_rx_ready"},    32'(rx_ready),    32'd0);
    endtask

    initial begin
        do_reset();

        start_stream(1); push_word(32'hDEADBEEF); finish_stream();
        run_and_check("one_word", 1'b0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'hFF;
            chk_eq("done_hold_rx_ready", 32'(rx_ready), 32'd0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        chk_eq("done_hold_n_writes", 32'(got_addr.size()), 32'd1);
        chk_eq("done_hold_addr", 32'(imem_wr_addr), 32'd0);
        chk_eq("done_hold_data", imem_wr_data, 32'hDEADBEEF);
        chk_eq("done_hold_flags", {30'd0, cpu_reset_n, boot_done}, 32'd3);

        do_reset();
        start_stream(3);
        push_word(32'h20080005); push_word(32'h20090007); push_word(32'h01095020);
        finish_stream();
        run_and_check("three_words", 1'b1);

        do_reset();
        start_stream(16'h0101);
        run_and_check("too_long", 1'b0);

        do_reset();
        start_stream(1); push_word(32'hAABBCCDD);
        drive("partial", 1'b0, 4);
        do_reset();
        start_stream(1); push_word(32'h12345678); finish_stream();
        run_and_check("after_reset", 1'b1);

        do_reset();
        start_stream(0); finish_stream();
        run_and_check("len_zero", 1'b0);

        do_reset();
        start_stream(MW);
        for (int i = 0; i < MW; i++) push_word($urandom);
        finish_stream();
        run_and_check("len_max", 1'b0);

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        start_stream(1); push_word(32'h11223344); finish_stream();
        chk_eq("csum_value", 32'(stream[6]), 32'h45);
        run_and_check("csum_good", 1'b0);

        do_reset();
        start_stream(1); push_word(32'h11223344); stream.push_back(8'h00);
        run_and_check("csum_bad", 1'b0);
`endif

        for (int t = 0; t < 6; t++) begin
            do_reset();
            start_stream($urandom_range(0, 5));
            for (int i = 0; i < ((int'(stream[0]) << 8) | int'(stream[1])); i++) push_word($urandom);
            finish_stream();
            run_and_check("random", 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
